// File: rtl/fsm10_stim_seq_if.sv
// Command push channel into the fsm10 stimulus sequencer.
// The bench or software drives the master side; the sequencer FIFO is the slave side.
interface fsm10_stim_seq_if #(
  parameter int CNT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/fsm10_stim_seq.sv
// Replays queued (op,len) commands as registered go/jmp patterns for fsm10; first drive 2 edges after push.
// cmd_ready is !full and never depends on a same-cycle pop; FSM10_SEQ_ABORT_EN adds a synchronous flush.
module fsm10_stim_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FSM10_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  fsm10_stim_seq_if.slave        cmd,
  output logic                   go,
  output logic                   jmp,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_GOJMP = 2'b10;
  localparam logic [1:0] OP_JMP   = 2'b11;

  typedef enum logic {ST_IDLE, ST_DRIVE} state_e;

  logic [CNT_W+1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q, go_d, jmp_q, jmp_d, busy_q, busy_d, done_q, done_d;

  logic             full, empty, push, pop, flush;
  logic [CNT_W+1:0] head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;

`ifdef FSM10_SEQ_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign cmd.cmd_ready = !full && !flush;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = mem_q[rd_ptr_q];
  assign head_op       = head[CNT_W+1:CNT_W];
  assign head_len      = head[CNT_W-1:0];

  // {go,jmp} for one drive cycle; only STEP distinguishes its first cycle.
  function automatic logic [1:0] drive_f(input logic [1:0] op, input logic first);
    logic [1:0] gj;
    gj = 2'b00;
    case (op)
      OP_HOLD:  gj = 2'b00;
      OP_STEP:  gj = {first, 1'b0};
      OP_GOJMP: gj = 2'b11;
      OP_JMP:   gj = 2'b01;
      default:  gj = 2'b00;
    endcase
    return gj;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    jmp_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          pop    = !empty;
          if (empty) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d         = cnt_q - CNT_W'(1);
          {go_d, jmp_d} = drive_f(op_q, 1'b0);
          busy_d        = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop loads the head so its first drive cycle follows with no bubble.
    if (pop) begin
      state_d       = ST_DRIVE;
      op_d          = head_op;
      cnt_d         = head_len;
      {go_d, jmp_d} = drive_f(head_op, 1'b1);
      busy_d        = 1'b1;
    end
    if (flush) begin
      pop     = 1'b0;
      state_d = ST_IDLE;
      go_d    = 1'b0;
      jmp_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_len};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      op_q     <= OP_HOLD;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      jmp_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      jmp_q    <= jmp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign go         = go_q;
  assign jmp        = jmp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_fsm10_stim_seq.sv
// Directed bench for fsm10_stim_seq: reset, STEP timing, back-to-back, FIFO full, push+pop, long length.
// Build with FSM10_SEQ_ABORT_EN defined to also exercise the abort flush.
module tb_fsm10_stim_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go, jmp, busy, done;
  logic [2:0] fifo_count;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef FSM10_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  fsm10_stim_seq_if #(.CNT_W(8)) cmd_if ();

  fsm10_stim_seq #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FSM10_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .cmd        (cmd_if),
    .go         (go),
    .jmp        (jmp),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Expected traces, one entry per cycle after the first drive edge.
  logic [1:0] step_gj   [6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic       step_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       step_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] b2b_op    [3] = '{2'b01, 2'b10, 2'b11};
  logic [7:0] b2b_len   [3] = '{8'd0, 8'd1, 8'd0};
  logic [1:0] b2b_gj    [6] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
  logic       b2b_done  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] full_op   [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
  logic [1:0] full_gj   [4] = '{2'b01, 2'b11, 2'b00, 2'b00};
  logic [2:0] full_cnt  [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
  logic       full_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] pp_gj     [4] = '{2'b10, 2'b01, 2'b11, 2'b00};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [7:0] len);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = len;
  endtask

  task automatic test_reset();
    set_cmd(1'b0, 2'b00, 8'd0);
    #3;
    n_cmp++; if ({go, jmp, busy, done} !== 4'b0000) begin n_err++; $display("FAIL reset_outs got=%b want=0000", {go, jmp, busy, done}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", cmd_if.cmd_ready); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_step();
    set_cmd(1'b1, 2'b01, 8'd3);
    tick();
    set_cmd(1'b0, 2'b00, 8'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if ({go, jmp} !== step_gj[i]) begin n_err++; $display("FAIL step_gj[%0d] got=%b want=%b", i, {go, jmp}, step_gj[i]); end
      n_cmp++; if (busy !== step_busy[i]) begin n_err++; $display("FAIL step_busy[%0d] got=%b want=%b", i, busy, step_busy[i]); end
      n_cmp++; if (done !== step_done[i]) begin n_err++; $display("FAIL step_done[%0d] got=%b want=%b", i, done, step_done[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) set_cmd(1'b1, b2b_op[i], b2b_len[i]);
      else       set_cmd(1'b0, 2'b00, 8'd0);
      tick();
      if (i >= 1) begin
        n_cmp++; if ({go, jmp} !== b2b_gj[i-1]) begin n_err++; $display("FAIL b2b_gj[%0d] got=%b want=%b", i-1, {go, jmp}, b2b_gj[i-1]); end
        n_cmp++; if (done !== b2b_done[i-1]) begin n_err++; $display("FAIL b2b_done[%0d] got=%b want=%b", i-1, done, b2b_done[i-1]); end
        if (done === 1'b1) dones++;
      end
    end
    n_cmp++; if (dones != 3) begin n_err++; $display("FAIL b2b_done_count got=%0d want=3", dones); end
  endtask

  task automatic test_fifo_full();
    int waited = 0;
    set_cmd(1'b1, 2'b00, 8'd20);
    tick();
    set_cmd(1'b0, 2'b00, 8'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_cmd(1'b1, full_op[k], 8'd0);
      n_cmp++; if (fifo_count !== 3'(k)) begin n_err++; $display("FAIL full_cnt_pre[%0d] got=%0d want=%0d", k, fifo_count, k); end
      n_cmp++; if (cmd_if.cmd_ready !== (k < 4)) begin n_err++; $display("FAIL full_ready[%0d] got=%b want=%b", k, cmd_if.cmd_ready, (k < 4)); end
      tick();
    end
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_cnt4 got=%0d want=4", fifo_count); end
    // Keep offering the 5th command: it must be refused even on the pop edge.
    for (int i = 0; i < 40; i++) begin
      tick();
      waited++;
      if (fifo_count !== 3'd4) break;
    end
    set_cmd(1'b0, 2'b00, 8'd0);
    n_cmp++; if (waited != 16) begin n_err++; $display("FAIL full_pop_time got=%0d want=16", waited); end
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL full_cnt3 got=%0d want=3", fifo_count); end
    n_cmp++; if ({go, jmp} !== 2'b10) begin n_err++; $display("FAIL full_first_gj got=%b want=10", {go, jmp}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({go, jmp} !== full_gj[i]) begin n_err++; $display("FAIL full_gj[%0d] got=%b want=%b", i, {go, jmp}, full_gj[i]); end
      n_cmp++; if (fifo_count !== full_cnt[i]) begin n_err++; $display("FAIL full_cnt[%0d] got=%0d want=%0d", i, fifo_count, full_cnt[i]); end
      n_cmp++; if (busy !== full_busy[i]) begin n_err++; $display("FAIL full_busy[%0d] got=%b want=%b", i, busy, full_busy[i]); end
    end
    tick();
  endtask

  task automatic test_push_pop();
    set_cmd(1'b1, 2'b00, 8'd2);
    tick();
    set_cmd(1'b1, 2'b01, 8'd0);
    tick();
    set_cmd(1'b1, 2'b11, 8'd0);
    tick();
    set_cmd(1'b0, 2'b00, 8'd0);
    tick();
    n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL pp_cnt_before got=%0d want=2", fifo_count); end
    set_cmd(1'b1, 2'b10, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      set_cmd(1'b0, 2'b00, 8'd0);
      if (i == 0) begin
        n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL pp_cnt_after got=%0d want=2", fifo_count); end
      end
      n_cmp++; if ({go, jmp} !== pp_gj[i]) begin n_err++; $display("FAIL pp_gj[%0d] got=%b want=%b", i, {go, jmp}, pp_gj[i]); end
    end
    tick();
  endtask

  task automatic test_max_len();
    int  jcnt    = 0;
    logic saw_go = 1'b0;
    logic got_dn = 1'b0;
    set_cmd(1'b1, 2'b11, 8'd255);
    tick();
    set_cmd(1'b0, 2'b00, 8'd0);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (jmp === 1'b1) jcnt++;
      if (go === 1'b1) saw_go = 1'b1;
      if (done === 1'b1) begin got_dn = 1'b1; break; end
    end
    n_cmp++; if (got_dn !== 1'b1) begin n_err++; $display("FAIL maxlen_done got=%b want=1", got_dn); end
    n_cmp++; if (jcnt != 256) begin n_err++; $display("FAIL maxlen_cycles got=%0d want=256", jcnt); end
    n_cmp++; if (saw_go !== 1'b0) begin n_err++; $display("FAIL maxlen_go got=%b want=0", saw_go); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    set_cmd(1'b1, 2'b10, 8'd5);
    tick();
    set_cmd(1'b1, 2'b00, 8'd0);
    tick();
    set_cmd(1'b0, 2'b00, 8'd0);
    n_cmp++; if ({go, jmp, busy} !== 3'b111) begin n_err++; $display("FAIL rmid_drive got=%b want=111", {go, jmp, busy}); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL rmid_queued got=%0d want=1", fifo_count); end
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({go, jmp, busy, done} !== 4'b0000) begin n_err++; $display("FAIL rmid_outs got=%b want=0000", {go, jmp, busy, done}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rmid_after got=%b want=0", saw); end
  endtask

`ifdef FSM10_SEQ_ABORT_EN
  task automatic test_abort();
    set_cmd(1'b1, 2'b11, 8'd10);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_cmd(1'b1, 2'b10, 8'd0);
      tick();
    end
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL abort_queued got=%0d want=3", fifo_count); end
    abort = 1'b1;
    set_cmd(1'b1, 2'b01, 8'd0);
    #1;
    n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready got=%b want=0", cmd_if.cmd_ready); end
    tick();
    abort = 1'b0;
    set_cmd(1'b0, 2'b00, 8'd0);
    n_cmp++; if ({go, jmp, busy, done} !== 4'b0000) begin n_err++; $display("FAIL abort_outs got=%b want=0000", {go, jmp, busy, done}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL abort_count got=%0d want=0", fifo_count); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_after got=%b want=00", {busy, done}); end
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_back_to_back();
    test_fifo_full();
    test_push_pop();
    test_max_len();
`ifdef FSM10_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
